// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg: field modulus, response error codes and scheduler state encoding
package secp256k1_pkg;
  localparam int WIDTH_DEF = 256;
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  typedef enum logic [1:0] {ERR_OK, ERR_ZERO, ERR_RANGE, ERR_TIMEOUT} err_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LAUNCH, S_GUARD, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign rot = NREQ'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
  assign grant = |req ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/mod_inv_sched.sv
// mod_inv_sched: round-robin scheduler sharing one mod_inv engine among NREQ requesters
module mod_inv_sched
  import secp256k1_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int TIMEOUT = 4096,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] operand,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  busy,
  output logic                  inv_start,
  output logic [WIDTH-1:0]      inv_operand,
  output logic                  inv_abort,
  input  logic                  inv_done,
  input  logic [WIDTH-1:0]      inv_result
);
  state_t state;
  logic [IW-1:0] ptr, idx, gidx;
  logic [NREQ-1:0] grant;
  logic [CW-1:0] cnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req), .ptr(ptr), .grant(grant), .idx(gidx));
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ptr <= '0;
      idx <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= ERR_OK;
      inv_start <= 1'b0;
      inv_operand <= '0;
      inv_abort <= 1'b0;
    end else begin
      rsp_valid <= '0;
      inv_start <= 1'b0;
      inv_abort <= 1'b0;
      case (state)
        S_IDLE: if (|grant) begin
          idx <= gidx;
          inv_operand <= operand[gidx*WIDTH +: WIDTH];
          ptr <= gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1;
          state <= S_CHECK;
        end
        S_CHECK: if (inv_operand == '0 || inv_operand >= P) begin
          rsp_err <= inv_operand == '0 ? ERR_ZERO : ERR_RANGE;
          rsp_data <= '0;
          rsp_valid <= NREQ'(1) << idx;
          state <= S_RESP;
        end else begin
          inv_start <= 1'b1;
          state <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_GUARD;
        // done is not sampled here: it may still be the previous operation's level
        S_GUARD: begin
          cnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (inv_done) begin
          rsp_data <= inv_result;
          rsp_err <= ERR_OK;
          rsp_valid <= NREQ'(1) << idx;
          state <= S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          inv_abort <= 1'b1;
          rsp_data <= '0;
          rsp_err <= ERR_TIMEOUT;
          rsp_valid <= NREQ'(1) << idx;
          state <= S_RESP;
        end else cnt <= cnt + 1'b1;
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
